// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter sending SYNC_WORD, an MSB-first payload and an idle gap.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx #(
    parameter logic [4:0] SYNC_WORD = 5'b11011,
    parameter int          DATA_W    = 8,
    parameter int          IDLE_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              dout,
    output logic              dout_en,
    output logic              frame_start,
    output logic              frame_done
);

    localparam int MAX_LEN = (DATA_W > 5) ? DATA_W : 5;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [3:0]       GAP_LAST  = 4'(IDLE_GAP - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PAR,
        GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        GAP
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              data_ready_q, data_ready_d;
    logic              dout_q, dout_d;
    logic              dout_en_q, dout_en_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_done_q, frame_done_d;
    logic [2:0]        sync_idx;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            shift_q       <= '0;
            data_ready_q  <= 1'b0;
            dout_q        <= 1'b0;
            dout_en_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            shift_q       <= shift_d;
            data_ready_q  <= data_ready_d;
            dout_q        <= dout_d;
            dout_en_q     <= dout_en_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shift_d   = shift_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_valid && data_ready_q) begin
                    state_d   = SYNC;
                    bit_cnt_d = '0;
                    shift_d   = data_in;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                end
            end
            SYNC: begin
                if (bit_cnt_q == SYNC_LAST) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
                    state_d   = PAR;
`else
                    if (IDLE_GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    shift_d   = shift_q << 1;
                end
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PAR: begin
                gap_cnt_d = '0;
                if (IDLE_GAP == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
`endif
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain flop.
    always_comb begin
        sync_idx      = 3'd4 - 3'(bit_cnt_d);
        data_ready_d  = (state_d == IDLE);
        dout_d        = 1'b0;
        dout_en_d     = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        case (state_d)
            SYNC: begin
                dout_d        = SYNC_WORD[sync_idx];
                dout_en_d     = 1'b1;
                frame_start_d = (bit_cnt_d == '0);
            end
            DATA: begin
                dout_d    = shift_d[DATA_W-1];
                dout_en_d = 1'b1;
`ifndef SEQ_FRAME_TX_PARITY_EN
                frame_done_d = (bit_cnt_d == DATA_LAST);
`endif
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PAR: begin
                dout_d       = parity_d;
                dout_en_d    = 1'b1;
                frame_done_d = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign data_ready  = data_ready_q;
    assign dout        = dout_q;
    assign dout_en     = dout_en_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed vector bench for seq_frame_tx with a default instance and an IDLE_GAP=0 instance.
// Honours SEQ_FRAME_TX_PARITY_EN when the design is built with parity.
module tb_seq_frame_tx;

    localparam int DATA_W = 8;
`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PERIOD_A = 5 + DATA_W + P + 2 + 1;
    localparam int PERIOD_B = 5 + DATA_W + P + 0 + 1;

    typedef struct {
        logic [7:0]  payload;
        logic [12:0] bits;
        logic        parity;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       data_valid;
    logic [7:0] data_in;
    logic       data_ready, dout, dout_en, frame_start, frame_done;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready, b_dout, b_dout_en, b_start, b_done;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[5];

    always #5 clk = ~clk;

    seq_frame_tx #(.SYNC_WORD(5'b11011), .DATA_W(DATA_W), .IDLE_GAP(2)) dut_a (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .dout(dout), .dout_en(dout_en),
        .frame_start(frame_start), .frame_done(frame_done)
    );

    seq_frame_tx #(.SYNC_WORD(5'b11011), .DATA_W(DATA_W), .IDLE_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_data), .data_valid(b_valid),
        .data_ready(b_ready), .dout(b_dout), .dout_en(b_dout_en),
        .frame_start(b_start), .frame_done(b_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic waitReady(input string name);
        int n = 0;
        while (data_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput(name, 32'(data_ready), 1);
    endtask

    // One complete frame on instance A, checked cycle by cycle including the loopback detector.
    task automatic applyStimulus(input vec_t v);
        logic [4:0] hist = '0;
        waitReady("ready_before_accept");
        data_valid = 1'b1;
        data_in    = v.payload;
        tick();
        data_valid = 1'b0;
        data_in    = ~v.payload;
        for (int i = 0; i < 13; i++) begin
            hist = {hist[3:0], dout};
            checkOutput($sformatf("dout_bit%0d_%0h", i, v.payload), 32'(dout), 32'(v.bits[12-i]));
            checkOutput("dout_en_frame", 32'(dout_en), 1);
            checkOutput("frame_start", 32'(frame_start), 32'(i == 0));
            checkOutput("frame_done", 32'(frame_done), 32'((i == 12) && (P == 0)));
            if (i == 4) checkOutput("loopback_detect", 32'(hist), 32'h1b);
            tick();
        end
`ifdef SEQ_FRAME_TX_PARITY_EN
        checkOutput("parity_bit", 32'(dout), 32'(v.parity));
        checkOutput("parity_en", 32'(dout_en), 1);
        checkOutput("parity_done", 32'(frame_done), 1);
        tick();
`endif
        for (int i = 0; i < 2; i++) begin
            checkOutput("gap_dout", 32'(dout), 0);
            checkOutput("gap_dout_en", 32'(dout_en), 0);
            checkOutput("gap_ready", 32'(data_ready), 0);
            checkOutput("gap_done", 32'(frame_done), 0);
            tick();
        end
        checkOutput("idle_ready", 32'(data_ready), 1);
        checkOutput("idle_dout", 32'(dout), 0);
        checkOutput("idle_dout_en", 32'(dout_en), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        v;
        int          seen;
        logic [12:0] b_bits;

        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        b_valid    = 1'b0;
        b_data     = 8'h00;
        tick();
        tick();
        checkOutput("reset_ready", 32'(data_ready), 0);
        checkOutput("reset_dout", 32'(dout), 0);
        checkOutput("reset_dout_en", 32'(dout_en), 0);
        checkOutput("reset_start", 32'(frame_start), 0);
        checkOutput("reset_done", 32'(frame_done), 0);
        checkOutput("reset_b_ready", 32'(b_ready), 0);
        reset = 1'b0;
        tick();
        checkOutput("ready_after_reset", 32'(data_ready), 1);
        checkOutput("b_ready_after_reset", 32'(b_ready), 1);

        // Reset and accept on the same edge: reset must win.
        reset      = 1'b1;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        tick();
        checkOutput("coincide_ready", 32'(data_ready), 0);
        checkOutput("coincide_dout_en", 32'(dout_en), 0);
        checkOutput("coincide_start", 32'(frame_start), 0);
        reset      = 1'b0;
        data_valid = 1'b0;
        tick();
        checkOutput("coincide_ready_after", 32'(data_ready), 1);
        tick();
        checkOutput("coincide_no_frame", 32'(dout_en), 0);
        checkOutput("coincide_no_start", 32'(frame_start), 0);

        vecs[0] = '{8'hA5, 13'b11011_10100101, 1'b0};
        vecs[1] = '{8'h07, 13'b11011_00000111, 1'b1};
        vecs[2] = '{8'h3C, 13'b11011_00111100, 1'b0};
        vecs[3] = '{8'hDB, 13'b11011_11011011, 1'b0};
        vecs[4] = '{8'h80, 13'b11011_10000000, 1'b1};
        for (int k = 0; k < 5; k++) applyStimulus(vecs[k]);

        for (int k = 0; k < 4; k++) begin
            v.payload = 8'($urandom);
            v.bits    = {5'b11011, v.payload};
            v.parity  = ^v.payload;
            applyStimulus(v);
        end

        // Reset during the third data bit aborts the frame.
        waitReady("abort_ready");
        data_valid = 1'b1;
        data_in    = 8'hFF;
        tick();
        data_valid = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        checkOutput("abort_pre_dout", 32'(dout), 1);
        checkOutput("abort_pre_dout_en", 32'(dout_en), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_dout", 32'(dout), 0);
        checkOutput("abort_dout_en", 32'(dout_en), 0);
        checkOutput("abort_done", 32'(frame_done), 0);
        checkOutput("abort_ready_low", 32'(data_ready), 0);
        tick();
        checkOutput("abort_ready_high", 32'(data_ready), 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (frame_done || dout_en) seen++;
            tick();
        end
        checkOutput("abort_no_residue", 32'(seen), 0);

        // data_valid held high: 8'h00 then 8'hFF, second payload sampled at its own accept.
        waitReady("b2b_ready");
        data_valid = 1'b1;
        data_in    = 8'h00;
        tick();
        data_in = 8'hFF;
        for (int c = 1; c <= PERIOD_A; c++) begin
            checkOutput($sformatf("b2b_start_c%0d", c), 32'(frame_start), 32'(c == 1));
            if (c >= 6 && c <= 13) checkOutput("b2b_payload0", 32'(dout), 0);
            tick();
        end
        checkOutput("b2b_start_second", 32'(frame_start), 1);
        data_valid = 1'b0;
        data_in    = 8'h00;
        for (int c = 2; c <= 13; c++) begin
            tick();
            if (c >= 6) checkOutput("b2b_payload1", 32'(dout), 1);
        end
        waitReady("b2b_ready_end");

        // IDLE_GAP=0 instance: one idle cycle between back-to-back 8'h1B frames.
        b_bits  = 13'b11011_00011011;
        b_valid = 1'b1;
        b_data  = 8'h1B;
        tick();
        for (int c = 1; c <= PERIOD_B; c++) begin
            checkOutput($sformatf("g0_start_c%0d", c), 32'(b_start), 32'(c == 1));
            checkOutput($sformatf("g0_dout_en_c%0d", c), 32'(b_dout_en), 32'(c <= 13 + P));
            checkOutput($sformatf("g0_done_c%0d", c), 32'(b_done), 32'(c == 13 + P));
            if (c <= 13) checkOutput($sformatf("g0_dout_c%0d", c), 32'(b_dout), 32'(b_bits[13-c]));
            if (c == PERIOD_B) begin
                checkOutput("g0_idle_dout", 32'(b_dout), 0);
                checkOutput("g0_idle_ready", 32'(b_ready), 1);
            end
            tick();
        end
        checkOutput("g0_start_second", 32'(b_start), 1);
        b_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checkOutput("g0_ready_end", 32'(b_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
